usb_endpoint_buffer: RTL and testbench

Parametrised successor to the USB endpoint data buffer: a single-port-pair circular FIFO shared by the AHB-side TX path and the USB RX path, with configurable data width and depth. Adds full/empty flags, sticky overflow/underflow errors, defined write and read arbitration, and optional RX packet commit/rollback so packets failing CRC are discarded without flushing. Sits between the AHB-lite slave interface and the USB TX/RX controllers.

---
 rtl/usb_buf_pkg.sv | 26 ++
 rtl/usb_buf_ptr_ctrl.sv | 146 ++++++++++++++
 rtl/usb_endpoint_buffer.sv | 82 ++++++++
 tb/tb_usb_endpoint_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_buf_pkg.sv
// Shared constants and arbitration types for the USB endpoint buffer.
package usb_buf_pkg;

  localparam int USB_BUF_DATA_W = 8;
  localparam int USB_BUF_DEPTH  = 64;

  // One-hot request source chosen by write or read arbitration
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_TX   = 2'b01,
    SRC_RX   = 2'b10
  } src_e;

  // RX side always wins when both sides request in the same cycle
  function automatic src_e pick_src(input logic tx_req, input logic rx_req);
    src_e src;
    src = SRC_NONE;
    if (rx_req) begin
      src = SRC_RX;
    end else if (tx_req) begin
      src = SRC_TX;
    end
    return src;
  endfunction

endpackage

// File: rtl/usb_buf_ptr_ctrl.sv
// Pointer, occupancy and error-flag control for the USB endpoint buffer.
// Optional feature macro: USB_EPB_ROLLBACK_EN (RX packet commit/rollback).
// total_q counts every stored entry (drives full); occ_q counts readable
// entries (drives empty and buffer_occupancy). They differ only while an RX
// packet is uncommitted.
module usb_buf_ptr_ctrl
  import usb_buf_pkg::*;
#(
  parameter int DEPTH = USB_BUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             flush,
  input  logic             store_tx_data,
  input  logic             store_rx_data,
  input  logic             get_tx_data,
  input  logic             get_rx_data,
  input  logic             rx_commit,
  input  logic             rx_abort,
  output logic             wr_en,
  output logic             wr_sel_rx,
  output logic [PTR_W-1:0] wr_addr,
  output logic [PTR_W-1:0] rd_addr,
  output logic             rd_tx,
  output logic             rd_rx,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] total_q, total_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  src_e wsrc, rsrc;
  logic clr, full_now, empty_now, push_ok, pop_ok;

`ifdef USB_EPB_ROLLBACK_EN
  logic [PTR_W-1:0] cptr_q, cptr_d;
`else
  logic unused_rollback;
  assign unused_rollback = rx_commit | rx_abort;
`endif

  // Decode requests: arbitration winners and whether they can be served
  always_comb begin
    wsrc      = pick_src(store_tx_data, store_rx_data);
    rsrc      = pick_src(get_tx_data, get_rx_data);
    clr       = clear | flush;
    full_now  = (total_q == DEPTH_OCC);
    empty_now = (occ_q == '0);
    push_ok   = !clr && (wsrc != SRC_NONE) && !full_now;
    pop_ok    = !clr && (rsrc != SRC_NONE) && !empty_now;
  end

  // Next-state for pointers, counters and sticky errors; clear/flush overrides all
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(push_ok);
    rptr_d  = rptr_q + PTR_W'(pop_ok);
    total_d = total_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    occ_d   = total_d;
    ovf_d   = ovf_q | (!clr && ((store_tx_data && store_rx_data) ||
                                ((wsrc != SRC_NONE) && full_now)));
    udf_d   = udf_q | (!clr && (rsrc != SRC_NONE) && empty_now);
`ifdef USB_EPB_ROLLBACK_EN
    cptr_d = cptr_q;
    if (rx_abort) begin
      // Abort wins over commit and discards any push made this cycle
      wptr_d  = cptr_q;
      occ_d   = occ_q - OCC_W'(pop_ok);
      total_d = occ_d;
    end else if (rx_commit || (push_ok && (wsrc == SRC_TX))) begin
      // Commit point moves to the write pointer including this cycle's push
      cptr_d = wptr_d;
    end else begin
      occ_d = occ_q - OCC_W'(pop_ok);
    end
    if (clr) begin
      cptr_d = '0;
    end
`endif
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      total_d = '0;
      occ_d   = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      total_q <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
`ifdef USB_EPB_ROLLBACK_EN
      cptr_q  <= '0;
`endif
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      total_q <= total_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
`ifdef USB_EPB_ROLLBACK_EN
      cptr_q  <= cptr_d;
`endif
    end
  end

  // Array control and status outputs
  always_comb begin
`ifdef USB_EPB_ROLLBACK_EN
    wr_en = push_ok && !rx_abort;
`else
    wr_en = push_ok;
`endif
    wr_sel_rx = (wsrc == SRC_RX);
    wr_addr   = wptr_q;
    rd_addr   = rptr_q;
    rd_rx     = pop_ok && (rsrc == SRC_RX);
    rd_tx     = pop_ok && (rsrc == SRC_TX);
    occupancy = occ_q;
    full      = full_now;
    empty     = empty_now;
    overflow  = ovf_q;
    underflow = udf_q;
  end

endmodule

// File: rtl/usb_endpoint_buffer.sv
// USB endpoint data buffer: circular FIFO shared by the AHB TX path and the
// USB RX path. Holds the storage array and output muxing; pointer control
// lives in usb_buf_ptr_ctrl.
// Optional feature macro: USB_EPB_ROLLBACK_EN (RX packet commit/rollback).
module usb_endpoint_buffer
  import usb_buf_pkg::*;
#(
  parameter int DATA_W = USB_BUF_DATA_W,
  parameter int DEPTH  = USB_BUF_DEPTH,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              store_rx_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              get_tx_data,
  input  logic              get_rx_data,
  input  logic              rx_commit,
  input  logic              rx_abort,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head;
  logic              wr_en, wr_sel_rx, rd_tx, rd_rx;
  logic [PTR_W-1:0]  wr_addr, rd_addr;

  usb_buf_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .OCC_W (OCC_W)
  ) u_ptr_ctrl (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (clear),
    .flush         (flush),
    .store_tx_data (store_tx_data),
    .store_rx_data (store_rx_data),
    .get_tx_data   (get_tx_data),
    .get_rx_data   (get_rx_data),
    .rx_commit     (rx_commit),
    .rx_abort      (rx_abort),
    .wr_en         (wr_en),
    .wr_sel_rx     (wr_sel_rx),
    .wr_addr       (wr_addr),
    .rd_addr       (rd_addr),
    .rd_tx         (rd_tx),
    .rd_rx         (rd_rx),
    .occupancy     (buffer_occupancy),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_sel_rx ? rx_packet_data : tx_data;
    end
  end

  // Head entry goes only to the served pop; the other output stays 0
  always_comb begin
    head           = mem_q[rd_addr];
    tx_packet_data = rd_tx ? head : '0;
    rx_data        = rd_rx ? head : '0;
  end

endmodule

// File: tb/tb_usb_endpoint_buffer.sv
// Directed table-driven bench for usb_endpoint_buffer (DATA_W=8, DEPTH=4).
// Each vector: inputs held for one cycle; outputs sampled mid-cycle, so
// registered expectations reflect the state before that vector's edge.
module tb_usb_endpoint_buffer;

  localparam logic [7:0] IDLE = 8'h00, CLR = 8'h80, FLS = 8'h40, STX = 8'h20,
                         SRX = 8'h10, GTX = 8'h08, GRX = 8'h04, CMT = 8'h02,
                         ABT = 8'h01;
  // flag bits: {full, empty, overflow, underflow}
  localparam logic [3:0] F_N = 4'b0000, F_F = 4'b1000, F_E = 4'b0100,
                         F_O = 4'b0010, F_U = 4'b0001;

  typedef struct {
    logic [7:0] ctl;
    logic [7:0] txd;
    logic [7:0] rxd;
    logic [7:0] etx;
    logic [7:0] erx;
    logic [2:0] eocc;
    logic [3:0] eflg;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst, clear, flush, store_tx_data, store_rx_data;
  logic       get_tx_data, get_rx_data, rx_commit, rx_abort;
  logic [7:0] tx_data, rx_packet_data, tx_packet_data, rx_data;
  logic [2:0] buffer_occupancy;
  logic       full, empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  usb_endpoint_buffer #(.DATA_W(8), .DEPTH(4)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .clear            (clear),
    .flush            (flush),
    .store_tx_data    (store_tx_data),
    .tx_data          (tx_data),
    .store_rx_data    (store_rx_data),
    .rx_packet_data   (rx_packet_data),
    .get_tx_data      (get_tx_data),
    .get_rx_data      (get_rx_data),
    .rx_commit        (rx_commit),
    .rx_abort         (rx_abort),
    .tx_packet_data   (tx_packet_data),
    .rx_data          (rx_data),
    .buffer_occupancy (buffer_occupancy),
    .full             (full),
    .empty            (empty),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] ctl, input logic [7:0] txd,
                              input logic [7:0] rxd, input logic [7:0] etx,
                              input logic [7:0] erx, input logic [2:0] eocc,
                              input logic [3:0] eflg);
    vec_t v;
    v.ctl = ctl; v.txd = txd; v.rxd = rxd; v.etx = etx; v.erx = erx;
    v.eocc = eocc; v.eflg = eflg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    clear          = v.ctl[7];
    flush          = v.ctl[6];
    store_tx_data  = v.ctl[5];
    store_rx_data  = v.ctl[4];
    get_tx_data    = v.ctl[3];
    get_rx_data    = v.ctl[2];
    rx_commit      = v.ctl[1];
    rx_abort       = v.ctl[0];
    tx_data        = v.txd;
    rx_packet_data = v.rxd;
  endtask

  task automatic check_vec(input vec_t v, input string name);
    $display("%s: ctl=%02h tx_out=%02h rx_out=%02h occ=%0d full=%0b empty=%0b ovf=%0b udf=%0b",
             name, v.ctl, tx_packet_data, rx_data, buffer_occupancy, full, empty,
             overflow, underflow);
    chk({name, "/tx_packet_data"}, 32'(tx_packet_data), 32'(v.etx));
    chk({name, "/rx_data"},        32'(rx_data),        32'(v.erx));
    chk({name, "/occupancy"},      32'(buffer_occupancy), 32'(v.eocc));
    chk({name, "/full"},           32'(full),      32'(v.eflg[3]));
    chk({name, "/empty"},          32'(empty),     32'(v.eflg[2]));
    chk({name, "/overflow"},       32'(overflow),  32'(v.eflg[1]));
    chk({name, "/underflow"},      32'(underflow), 32'(v.eflg[0]));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #2;
    check_vec(v, name);
  endtask

  vec_t tbl[$];

  initial begin
    // basic tx push / pop
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(STX,  8'h01, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(STX,  8'h02, 8'h00, 8'h00, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(STX,  8'h03, 8'h00, 8'h00, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(STX,  8'h04, 8'h00, 8'h00, 8'h00, 3'd3, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h01, 8'h00, 3'd4, F_F));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h02, 8'h00, 3'd3, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h03, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h04, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    // overflow on 5th push, drain, underflow
    tbl.push_back(mk(STX,  8'hAA, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(STX,  8'hBB, 8'h00, 8'h00, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(STX,  8'hCC, 8'h00, 8'h00, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(STX,  8'hDD, 8'h00, 8'h00, 8'h00, 3'd3, F_N));
    tbl.push_back(mk(STX,  8'hEE, 8'h00, 8'h00, 8'h00, 3'd4, F_F));
    tbl.push_back(mk(GRX,  8'h00, 8'h00, 8'h00, 8'hAA, 3'd4, F_F | F_O));
    tbl.push_back(mk(GRX,  8'h00, 8'h00, 8'h00, 8'hBB, 3'd3, F_O));
    tbl.push_back(mk(GRX,  8'h00, 8'h00, 8'h00, 8'hCC, 3'd2, F_O));
    tbl.push_back(mk(GRX,  8'h00, 8'h00, 8'h00, 8'hDD, 3'd1, F_O));
    tbl.push_back(mk(GRX,  8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E | F_O));
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E | F_O | F_U));
    // clear overrides a simultaneous push and pop
    tbl.push_back(mk(CLR | STX | GTX, 8'h77, 8'h00, 8'h00, 8'h00, 3'd0, F_E | F_O | F_U));
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    // wrap-around: push 3, pop 3, push 4, pop 4
    tbl.push_back(mk(STX,  8'h11, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(STX,  8'h12, 8'h00, 8'h00, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(STX,  8'h13, 8'h00, 8'h00, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h11, 8'h00, 3'd3, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h12, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h13, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(STX,  8'h21, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(STX,  8'h22, 8'h00, 8'h00, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(STX,  8'h23, 8'h00, 8'h00, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(STX,  8'h24, 8'h00, 8'h00, 8'h00, 3'd3, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h21, 8'h00, 3'd4, F_F));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h22, 8'h00, 3'd3, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h23, 8'h00, 3'd2, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h24, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    // write and read arbitration (commit keeps rx pushes readable in rollback builds)
    tbl.push_back(mk(SRX | STX | CMT, 8'h33, 8'h55, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(GTX | GRX, 8'h00, 8'h00, 8'h00, 8'h55, 3'd1, F_O));
    tbl.push_back(mk(SRX | STX | CMT, 8'h33, 8'h55, 8'h00, 8'h00, 3'd0, F_E | F_O));
    tbl.push_back(mk(FLS,  8'h00, 8'h00, 8'h00, 8'h00, 3'd1, F_O));
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    // push and pop together at occupancy 1
    tbl.push_back(mk(STX,  8'h66, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    tbl.push_back(mk(STX | GTX, 8'h77, 8'h00, 8'h66, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(GTX,  8'h00, 8'h00, 8'h77, 8'h00, 3'd1, F_N));
    tbl.push_back(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));

    n_rst = 1'b0;
    drive(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset in the middle of operation discards the entry
    run_vec(mk(STX, 8'h99, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "rst_push");
    @(negedge clk);
    drive(mk(GTX, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    n_rst = 1'b0;
    #2;
    check_vec(mk(GTX, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "rst_async");
    @(negedge clk);
    n_rst = 1'b1;
    drive(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E));
    run_vec(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "rst_after");

`ifdef USB_EPB_ROLLBACK_EN
    // uncommitted rx entries are invisible, count toward full, and abort drops them
    run_vec(mk(SRX, 8'h00, 8'hA1, 8'h00, 8'h00, 3'd0, F_E), "rb_push1");
    run_vec(mk(SRX, 8'h00, 8'hA2, 8'h00, 8'h00, 3'd0, F_E), "rb_push2");
    run_vec(mk(SRX, 8'h00, 8'hA3, 8'h00, 8'h00, 3'd0, F_E), "rb_push3");
    run_vec(mk(SRX, 8'h00, 8'hA4, 8'h00, 8'h00, 3'd0, F_E), "rb_push4");
    run_vec(mk(ABT, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_F | F_E), "rb_abort");
    run_vec(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "rb_after_abort");
    run_vec(mk(SRX, 8'h00, 8'hB1, 8'h00, 8'h00, 3'd0, F_E), "rb_pushB1");
    run_vec(mk(SRX | CMT, 8'h00, 8'hB2, 8'h00, 8'h00, 3'd0, F_E), "rb_pushB2_commit");
    run_vec(mk(GRX, 8'h00, 8'h00, 8'h00, 8'hB1, 3'd2, F_N), "rb_popB1");
    run_vec(mk(GRX, 8'h00, 8'h00, 8'h00, 8'hB2, 3'd1, F_N), "rb_popB2");
    run_vec(mk(SRX, 8'h00, 8'hC1, 8'h00, 8'h00, 3'd0, F_E), "rb_pushC1");
    run_vec(mk(CMT | ABT, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "rb_abort_wins");
    run_vec(mk(GRX, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "rb_pop_empty");
    run_vec(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E | F_U), "rb_underflow");
`else
    // without rollback, rx pushes are readable at once and abort is ignored
    run_vec(mk(SRX | ABT, 8'h00, 8'hA1, 8'h00, 8'h00, 3'd0, F_E), "nr_push_abort");
    run_vec(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, F_N), "nr_kept");
    run_vec(mk(GRX, 8'h00, 8'h00, 8'h00, 8'hA1, 3'd1, F_N), "nr_pop");
    run_vec(mk(IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, F_E), "nr_empty");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
